// File: rtl/piso_tx_controller_pkg.sv
// Shared types and default sizing for the PISO transmit controller and its bench.
package piso_tx_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam int unsigned DefWidth     = 4;
  localparam int unsigned DefGapCycles = 1;

endpackage

// File: rtl/piso_shift_core.sv
// Right-shift PISO register: LSB is presented on serial_out, MSB fills with zero.
module piso_shift_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= parallel_in;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  assign serial_out = shift_q[0];

endmodule

// File: rtl/piso_tx_controller.sv
// Frame sequencer: accepts parallel words via valid/ready, shifts them out LSB first,
// then holds the line low for GAP_CYCLES idle cycles.
module piso_tx_controller
  import piso_tx_controller_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_valid,
  input  logic [WIDTH-1:0]         tx_data,
  output logic                     tx_ready,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            last_bit;
  logic            accept;
  logic            core_bit;

  assign last_bit = (bit_cnt_q == CntW'(WIDTH - 1));
  assign accept   = tx_valid && tx_ready;

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .shift_en   (state_q == StShift),
    .parallel_in(tx_data),
    .serial_out (core_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else if (!accept) begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With no gap, the last-bit cycle also accepts so frames can run back to back.
  always_comb begin
    tx_ready   = 1'b0;
    serial_out = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    bit_index  = '0;
    unique case (state_q)
      StIdle: tx_ready = ~rst;
      StShift: begin
        busy       = 1'b1;
        serial_out = core_bit;
        bit_index  = bit_cnt_q;
        frame_done = last_bit;
        tx_ready   = ~rst && (GAP_CYCLES == 0) && last_bit;
      end
      StGap: busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_controller.sv
// Bench for piso_tx_controller: one instance with a 1-cycle gap, one with back-to-back frames.
module tb_piso_tx_controller;
  import piso_tx_controller_pkg::*;

  localparam int unsigned W = DefWidth;

  typedef struct packed {
    logic       sout;
    logic [1:0] idx;
    logic       fd;
    logic       busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_valid1, tx_valid0;
  logic [W-1:0] tx_data1, tx_data0;
  logic         tx_ready1, serial_out1, busy1, frame_done1;
  logic         tx_ready0, serial_out0, busy0, frame_done0;
  logic [1:0]   bit_index1, bit_index0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q1[$];
  exp_t q0[$];
  bit   acc1 = 1'b0;
  bit   acc0 = 1'b0;

  always #5 clk = ~clk;

  piso_tx_controller #(.WIDTH(W), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .serial_out(serial_out1), .busy(busy1), .frame_done(frame_done1), .bit_index(bit_index1)
  );

  piso_tx_controller #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
    .serial_out(serial_out0), .busy(busy0), .frame_done(frame_done0), .bit_index(bit_index0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected per-cycle outputs for one accepted word: WIDTH data bits then gap cycles.
  task automatic push_frame(input logic [W-1:0] w, input int gap, inout exp_t q[$]);
    exp_t e;
    for (int i = 0; i < int'(W); i++) begin
      e.sout = w[i];
      e.idx  = 2'(i);
      e.fd   = (i == int'(W) - 1);
      e.busy = 1'b1;
      q.push_back(e);
    end
    for (int g = 0; g < gap; g++) begin
      e = '{sout: 1'b0, idx: 2'd0, fd: 1'b0, busy: 1'b1};
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have, rdy;
    if (rst) begin
      check("rst_sout1", serial_out1, 0);
      check("rst_busy1", busy1, 0);
      check("rst_ready1", tx_ready1, 0);
      check("rst_fd1", frame_done1, 0);
      q1.delete();
      acc1 = 1'b0;
    end else begin
      have = (q1.size() > 0);
      e    = have ? q1.pop_front() : exp_t'(0);
      rdy  = !have;
      check("sout1", serial_out1, e.sout);
      check("idx1", bit_index1, e.idx);
      check("fd1", frame_done1, e.fd);
      check("busy1", busy1, e.busy);
      check("ready1", tx_ready1, rdy);
      acc1 = tx_valid1 && rdy;
      if (acc1) push_frame(tx_data1, 1, q1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   have, rdy;
    if (rst) begin
      check("rst_sout0", serial_out0, 0);
      check("rst_ready0", tx_ready0, 0);
      q0.delete();
      acc0 = 1'b0;
    end else begin
      have = (q0.size() > 0);
      e    = have ? q0.pop_front() : exp_t'(0);
      rdy  = !have || (e.fd && q0.size() == 0);
      check("sout0", serial_out0, e.sout);
      check("idx0", bit_index0, e.idx);
      check("fd0", frame_done0, e.fd);
      check("busy0", busy0, e.busy);
      check("ready0", tx_ready0, rdy);
      acc0 = tx_valid0 && rdy;
      if (acc0) push_frame(tx_data0, 0, q0);
    end
  end

  // Holds the word with valid high until the model says it was taken; valid stays high.
  task automatic send1(input logic [W-1:0] w);
    tx_valid1 = 1'b1;
    tx_data1  = w;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (acc1) break;
    end
    check("accept_timeout1", acc1, 1);
    #1;
  endtask

  task automatic send0(input logic [W-1:0] w);
    tx_valid0 = 1'b1;
    tx_data0  = w;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (acc0) break;
    end
    check("accept_timeout0", acc0, 1);
    #1;
  endtask

  task automatic idle(input int n);
    tx_valid1 = 1'b0;
    tx_valid0 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    tx_valid1 = 1'b0;
    tx_valid0 = 1'b0;
    tx_data1  = '0;
    tx_data0  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single frame, then held valid across two words.
    send1(4'b1010);
    idle(6);
    send1(4'b1010);
    send1(4'b1111);
    idle(7);

    // Mid-frame valid pulse with different data must be ignored.
    send1(4'b1010);
    tx_valid1 = 1'b0;
    @(posedge clk); #1;
    tx_valid1 = 1'b1;
    tx_data1  = 4'b0110;
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    idle(5);

    // Reset after two bits of 4'b1111 aborts the frame immediately.
    send1(4'b1111);
    tx_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_sout", serial_out1, 0);
    check("abort_fd", frame_done1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    send1(4'b0011);
    idle(6);

    // Back-to-back frames on the gapless instance.
    send0(4'b1010);
    send0(4'b1111);
    idle(6);
    send0(4'b0110);
    idle(6);

    check("q1_drained", q1.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
